regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Controller that owns the single write port (PW, RW, LE) of the 32×32-bit register file and shares it between two writeback requesters: requester 0 (ALU writeback) and requester 1 (memory/load writeback). After reset it sequences a full register-file clear, then grants at most one write per cycle using round-robin priority. It suppresses writes to r0, which is the SPARC %g0 zero register. It sits between the writeback stage and the register file's write inputs; the read ports are untouched.

## Interface
- INIT_EN, 1: 1 = run the clear sequence after reset; 0 = go straight to ARB.
- INIT_VALUE, 32'h0000_0000: value written to every register during the clear sequence.
- R0_HARDWIRED, 1: 1 = force LE low for any granted write whose address is 0.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 write request.
- rw0  in  5  requester 0 destination register.
- pw0  in  32  requester 0 write data.
- gnt0  out  1  requester 0 grant (combinational).
- req1, rw1, pw1, gnt1: same as the requester 0 set, for requester 1.
- RW  out  5  register-file write address.
- PW  out  32  register-file write data.
- LE  out  1  register-file load enable.
- init_busy  out  1  high while the clear sequence is running.

## Operation
- The FSM has two states, INIT and ARB.
  - Reset enters INIT when INIT_EN=1 and ARB otherwise.
- INIT state:
  - A 5-bit counter cnt starts at 0.
  - Each cycle: LE=1, RW=cnt, PW=INIT_VALUE, gnt0=gnt1=0, init_busy=1.
  - cnt increments each cycle. When cnt=31 the FSM moves to ARB at that same edge.
  - The clear takes 32 cycles. r0 is written too; R0_HARDWIRED does not apply during INIT.
- ARB state:
  - init_busy=0.
  - Only one requester active: it is granted.
  - Both active: the requester named by the priority pointer ptr is granted (ptr=0 means requester 0).
  - Neither active: gnt0=gnt1=0, LE=0, and RW/PW are held at 0.
  - For the granted requester i: RW=rwi, PW=pwi, LE=1.
    - Exception: when R0_HARDWIRED=1 and rwi=0, LE=0, but gnti is still asserted so the request retires.
- Priority pointer ptr (1 bit):
  - It updates only on a cycle where both requesters are active. It then points to the requester that was not granted.
  - A single-requester cycle leaves ptr unchanged.
- Handshake rules:
  - A requester holds reqi, rwi and pwi stable until it samples gnti=1 at a rising edge. The write commits at that edge.
  - It may drop reqi or change rwi/pwi in the following cycle.
  - Requests are not queued: a losing requester simply keeps reqi high.
- Reset mid-operation:
  - Asserting rst_n low at any time immediately forces LE=0, gnt0=gnt1=0 and ptr=0.
  - It also sets init_busy=INIT_EN and cnt=0.
  - The clear sequence restarts from r0 after release.

## Timing
- Reset values (while rst_n=0):
  - LE=0, RW=0, PW=0, gnt0=0, gnt1=0.
  - init_busy=INIT_EN, ptr=0, cnt=0, state=INIT (or ARB if INIT_EN=0).
  - LE stays 0 during reset even though the state is INIT.
- Grant latency: zero cycles. gnti, RW, PW and LE are combinational from req/state in the same cycle, and the register updates at the next rising edge.
- Throughput: one write per cycle. With both requesters continuously active, grants alternate 0,1,0,1… starting from ptr.
- Requests asserted during INIT are held off. The first ARB cycle is cycle 33 after reset release and is a normal arbitration cycle with ptr=0.
- All outputs are glitch-free with respect to clk only if requester inputs change only after rising edges. Requesters are registered upstream.

## Test plan
- Reset/clear:
  - Release rst_n → 32 cycles of LE=1 with RW=0..31 and PW=0, init_busy=1.
  - At cycle 33: init_busy=0, LE=0. All registers read back 0.
- Single requester:
  - req0=1, rw0=5, pw0=32'hDEAD_BEEF → gnt0=1, gnt1=0, LE=1, RW=5, PW=DEADBEEF in the same cycle.
  - R5 reads DEADBEEF after the edge, and ptr is unchanged.
- Contention:
  - req0 and req1 held high for 4 cycles with rw0=3, rw1=4 → grants 0,1,0,1.
  - ptr ends at 0. R3 and R4 hold the last granted data.
- r0 suppression:
  - req1=1, rw1=0, pw1=32'h1234 → gnt1=1, LE=0, and r0 still reads 0.
  - With R0_HARDWIRED=0 the same stimulus gives LE=1.
- Requests during INIT:
  - req0=1 from reset release → gnt0=0 for 32 cycles, then gnt0=1 on the first ARB cycle.
- Reset mid-operation:
  - Assert rst_n at cycle 10 of INIT or mid-contention → LE=0 and gnt0/gnt1=0 immediately (asynchronous).
  - After release, the clear restarts at RW=0 and ptr=0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Write-port controller for the 32x32 register file. After reset it clears
// every register, then shares the single write port between the ALU
// writeback (requester 0) and the load writeback (requester 1) using
// round-robin priority. Writes to r0 can be suppressed so that it reads as
// the SPARC %g0 zero register.
module regfile_write_arbiter #(
  parameter bit          INIT_EN      = 1'b1,
  parameter logic [31:0] INIT_VALUE   = 32'h0000_0000,
  parameter bit          R0_HARDWIRED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [4:0]  rw0,
  input  logic [31:0] pw0,
  output logic        gnt0,
  input  logic        req1,
  input  logic [4:0]  rw1,
  input  logic [31:0] pw1,
  output logic        gnt1,
  output logic [4:0]  RW,
  output logic [31:0] PW,
  output logic        LE,
  output logic        init_busy
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = INIT_EN ? ST_INIT : ST_ARB;

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       ptr_q, ptr_d;   // 0: requester 0 wins the next tie
  logic       sel1;           // requester 1 is the granted one this cycle

  // State, clear counter and priority pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= 5'd0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state and write-port outputs. The outputs are also gated by rst_n
  // so the port goes quiet the instant reset is asserted, even though the
  // state register already sits in INIT at that moment.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    LE        = 1'b0;
    RW        = 5'd0;
    PW        = 32'd0;
    init_busy = 1'b0;
    sel1      = 1'b0;

    case (state_q)
      ST_INIT: begin
        // r0 is cleared too; suppression only applies to granted writes.
        init_busy = 1'b1;
        LE        = 1'b1;
        RW        = cnt_q;
        PW        = INIT_VALUE;
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = ST_ARB;
        end
      end
      ST_ARB: begin
        // Requester 1 wins when alone, or on a tie when the pointer says so.
        sel1 = req1 && (!req0 || ptr_q);
        if (req0 || req1) begin
          gnt0 = !sel1;
          gnt1 = sel1;
          RW   = sel1 ? rw1 : rw0;
          PW   = sel1 ? pw1 : pw0;
          // A write to r0 still retires (grant high) but never lands.
          LE   = !(R0_HARDWIRED && ((sel1 ? rw1 : rw0) == 5'd0));
        end
        // On a tie the loser gets priority next time.
        if (req0 && req1) begin
          ptr_d = !sel1;
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase

    if (!rst_n) begin
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      LE        = 1'b0;
      RW        = 5'd0;
      PW        = 32'd0;
      init_busy = INIT_EN;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter. A bench-side register file
// captures what the DUT writes; a queue holds the expected write-port
// state for each driven cycle, which is popped and compared mid-cycle.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [4:0]  rw0, rw1;
  logic [31:0] pw0, pw1;
  logic        gnt0, gnt1, LE, init_busy;
  logic [4:0]  RW;
  logic [31:0] PW;
  // Second instance with r0 writes allowed; only its LE is of interest.
  logic        gnt0_b, gnt1_b, LE_b, init_busy_b;
  logic [4:0]  RW_b;
  logic [31:0] PW_b;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic        le;
    logic [4:0]  rw;
    logic [31:0] pw;
    logic        busy;
  } port_t;

  port_t       exp_q[$];
  logic [31:0] rf[32];

  regfile_write_arbiter #(
    .INIT_EN(1'b1), .INIT_VALUE(32'h0000_0000), .R0_HARDWIRED(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .rw0(rw0), .pw0(pw0), .gnt0(gnt0),
    .req1(req1), .rw1(rw1), .pw1(pw1), .gnt1(gnt1),
    .RW(RW), .PW(PW), .LE(LE), .init_busy(init_busy)
  );

  regfile_write_arbiter #(
    .INIT_EN(1'b1), .INIT_VALUE(32'h0000_0000), .R0_HARDWIRED(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .rw0(rw0), .pw0(pw0), .gnt0(gnt0_b),
    .req1(req1), .rw1(rw1), .pw1(pw1), .gnt1(gnt1_b),
    .RW(RW_b), .PW(PW_b), .LE(LE_b), .init_busy(init_busy_b)
  );

  always #5 clk = ~clk;

  // Model of the register file being written.
  always @(posedge clk) begin
    if (LE) rf[RW] <= PW;
  end

  // Push the expected port state for the current cycle, compare it at the
  // falling edge, then return just after the next rising edge.
  task automatic step(input string tag, input logic g0, input logic g1,
                      input logic le, input logic [4:0] rw,
                      input logic [31:0] pw, input logic busy);
    port_t e, o;
    e = '{g0: g0, g1: g1, le: le, rw: rw, pw: pw, busy: busy};
    exp_q.push_back(e);
    @(negedge clk);
    o = '{g0: gnt0, g1: gnt1, le: LE, rw: RW, pw: PW, busy: init_busy};
    e = exp_q.pop_front();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got gnt0=%b gnt1=%b LE=%b RW=%0d PW=%h busy=%b, want gnt0=%b gnt1=%b LE=%b RW=%0d PW=%h busy=%b",
             tag, o.g0, o.g1, o.le, o.rw, o.pw, o.busy, e.g0, e.g1, e.le, e.rw, e.pw, e.busy);
    end
    $display("step %s: gnt0=%b gnt1=%b LE=%b RW=%0d PW=%h busy=%b",
             tag, o.g0, o.g1, o.le, o.rw, o.pw, o.busy);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string tag, input int idx, input logic [31:0] want);
    checks++;
    assert (rf[idx] === want) else begin
      errors++;
      $error("FAIL %s: r%0d got %h want %h", tag, idx, rf[idx], want);
    end
  endtask

  // Asynchronous reset must silence the port immediately.
  task automatic check_quiet(input string tag);
    checks++;
    assert ({gnt0, gnt1, LE, RW, PW, init_busy} === {3'b000, 5'd0, 32'd0, 1'b1}) else begin
      errors++;
      $error("FAIL %s: got gnt0=%b gnt1=%b LE=%b RW=%0d PW=%h busy=%b, want all 0 with busy=1",
             tag, gnt0, gnt1, LE, RW, PW, init_busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    req0 = 1'b1; rw0 = 5'd7; pw0 = 32'h0000_AAAA;
    req1 = 1'b0; rw1 = 5'd0; pw1 = 32'd0;
    @(posedge clk); #1;

    // Reset state: port idle, busy reflects INIT_EN, pending request held off.
    step("reset", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    rst_n = 1'b1;

    // Clear sequence with req0 already pending.
    for (int i = 0; i < 32; i++) step("init", 1'b0, 1'b0, 1'b1, 5'(i), 32'd0, 1'b1);
    for (int i = 0; i < 32; i++) check_reg("clear", i, 32'd0);

    // First ARB cycle grants the waiting requester.
    step("first_arb", 1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_AAAA, 1'b0);
    req0 = 1'b0;
    check_reg("first_arb_wr", 7, 32'h0000_AAAA);
    step("idle", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);

    // Single requester.
    req0 = 1'b1; rw0 = 5'd5; pw0 = 32'hDEAD_BEEF;
    step("single0", 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
    req0 = 1'b0;
    check_reg("single0_wr", 5, 32'hDEAD_BEEF);

    // Contention: pointer still 0, so 0,1,0,1. Winners change data next cycle.
    req0 = 1'b1; rw0 = 5'd3; pw0 = 32'h30;
    req1 = 1'b1; rw1 = 5'd4; pw1 = 32'h40;
    step("cont_a", 1'b1, 1'b0, 1'b1, 5'd3, 32'h30, 1'b0);
    pw0 = 32'h31;
    step("cont_b", 1'b0, 1'b1, 1'b1, 5'd4, 32'h40, 1'b0);
    pw1 = 32'h41;
    step("cont_c", 1'b1, 1'b0, 1'b1, 5'd3, 32'h31, 1'b0);
    step("cont_d", 1'b0, 1'b1, 1'b1, 5'd4, 32'h41, 1'b0);
    check_reg("cont_r3", 3, 32'h31);
    check_reg("cont_r4", 4, 32'h41);
    // Pointer back at 0: the next tie goes to requester 0 (pointer -> 1).
    step("cont_e", 1'b1, 1'b0, 1'b1, 5'd3, 32'h31, 1'b0);

    // Single requester 1 must leave the pointer at 1.
    req0 = 1'b0; pw1 = 32'h42;
    step("single1", 1'b0, 1'b1, 1'b1, 5'd4, 32'h42, 1'b0);
    req0 = 1'b1;
    step("tie_after_single", 1'b0, 1'b1, 1'b1, 5'd4, 32'h42, 1'b0);
    req0 = 1'b0; req1 = 1'b0;

    // r0 suppression: granted but not written; unsuppressed instance writes.
    req1 = 1'b1; rw1 = 5'd0; pw1 = 32'h0000_1234;
    checks++;
    #2;
    assert (LE_b === 1'b1 && gnt1_b === 1'b1) else begin
      errors++;
      $error("FAIL r0_open: got LE=%b gnt1=%b want LE=1 gnt1=1", LE_b, gnt1_b);
    end
    #2;
    step("r0_sup", 1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_1234, 1'b0);
    req1 = 1'b0;
    check_reg("r0_still_zero", 0, 32'd0);

    // Reset in the middle of contention.
    req0 = 1'b1; rw0 = 5'd3; pw0 = 32'h50;
    req1 = 1'b1; rw1 = 5'd4; pw1 = 32'h60;
    step("pre_rst", 1'b1, 1'b0, 1'b1, 5'd3, 32'h50, 1'b0);
    #2; rst_n = 1'b0; #1;
    check_quiet("rst_mid_cont");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) step("reinit", 1'b0, 1'b0, 1'b1, 5'(i), 32'd0, 1'b1);

    // Reset at cycle 10 of the clear.
    #2; rst_n = 1'b0; #1;
    check_quiet("rst_mid_init");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) step("reinit2", 1'b0, 1'b0, 1'b1, 5'(i), 32'd0, 1'b1);

    // Pointer was cleared by reset even though requester 1 was owed a turn.
    step("post_rst_a", 1'b1, 1'b0, 1'b1, 5'd3, 32'h50, 1'b0);
    step("post_rst_b", 1'b0, 1'b1, 1'b1, 5'd4, 32'h60, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    check_reg("post_rst_r3", 3, 32'h50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
